style_load_arbiter: RTL and testbench
=====================================

Name: style_load_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared computed-style register write port: 59-bit display value, 32-bit status counters.
- Up to NUM_REQ style-resolution units offer a display value plus its is_primitive_value and is_valid_display_value flags.
- The block grants one requester, holds the value, and issues a single-cycle load enable to the style register only when both flags are set.
- It counts committed and dropped loads for debug readout.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 59, display value width.
- CNT_W, 32, width of the load and drop counters.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset, sampled on posedge clock.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_data  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- req_primitive  in  NUM_REQ  is_primitive_value per requester.
- req_valid_disp  in  NUM_REQ  is_valid_display_value per requester.
- reg_stall  in  1  style register cannot accept a load this cycle.
- reg_d  out  DATA_W  data to the style register.
- reg_enable  out  1  load enable to the style register.
- grant_id  out  $clog2(NUM_REQ)  index of the requester currently held.
- busy  out  1  high in HOLD.
- load_count  out  CNT_W  committed loads.
- drop_count  out  CNT_W  discarded loads, where primitive & valid_disp == 0.

Behaviour:
- Reset: when reset==0 at posedge, the block enters the reset state.
  - state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 has first priority), hold register=0.
  - reg_d=0, reg_enable=0, grant_id=0, busy=0, load_count=0, drop_count=0.
  - req_ready is forced 0 while reset is low.
  - Reset mid-HOLD discards the held value with no enable and no count.
- Arbitration: combinational, in IDLE only. The winner is the first i with req_valid[i] set, scanning from rr_ptr+1 upward modulo NUM_REQ.
  - req_ready[winner]=1 in the same cycle; all other bits are 0.
  - A handshake completes when req_valid[i] & req_ready[i] at posedge.
- IDLE -> HOLD on any handshake. At that edge the block latches data, flags, and grant_id=winner, and sets rr_ptr=winner.
- HOLD:
  - req_ready=0, busy=1.
  - reg_d = held data (registered, stable throughout HOLD).
  - reg_enable = held_primitive & held_valid_disp & ~reg_stall (combinational).
  - If reg_stall=1, stay in HOLD with no count.
  - If reg_stall=0 and both flags are set, load_count++ and go to IDLE.
  - If reg_stall=0 and either flag is clear, reg_enable stays 0, drop_count++, and go to IDLE.
- Drops do not wait on reg_stall: a drop completes the first HOLD cycle regardless of reg_stall.
- Latency: handshake at edge N; reg_enable is high during cycle N+1 if not stalled. Baseline throughput is 1 load per 2 cycles.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Fairness: after requester k is granted, k has the lowest priority on the next arbitration. With all requesters requesting, grant order is 0,1,2,3,0,...
- A requester that deasserts req_valid before being granted is simply skipped; there is no latching of ungranted requests.
- reg_d and grant_id retain their last values in IDLE.

Optional Feature:
- Macro: STYLE_ARB_PIPELINE_EN.
- Defined: on the HOLD exit cycle (reg_stall=0), arbitration also runs and req_ready may assert.
  - A handshake on that edge reloads the hold register and stays in HOLD.
  - This gives back-to-back loads, with reg_enable high on consecutive cycles, for 1 load/cycle throughput.
  - rr_ptr updates per grant, with the same fairness order.
- Undefined: req_ready is asserted only in IDLE; throughput is 1 per 2 cycles as above.

Test Plan:
- Reset and single load:
  - Stimulus: hold reset=0 for 2 cycles, then release. Assert req_valid=4'b0100, req_data[2]=59'h1234, flags=1/1.
  - Response: req_ready=4'b0100 that cycle. Next cycle reg_enable=1, reg_d=59'h1234, grant_id=2. Then load_count=1 and busy=0.
- Round-robin:
  - Stimulus: req_valid=4'b1111 held for 8 grants, all flags 1.
  - Response: grant order 0,1,2,3,0,1,2,3; load_count=8; drop_count=0.
- Drop path:
  - Stimulus: requester 1 with primitive=1, valid_disp=0, data=59'hABC.
  - Response: reg_enable stays 0 through HOLD; drop_count=1; load_count unchanged; HOLD lasts 1 cycle even with reg_stall=1.
- Stall:
  - Stimulus: load from requester 3 with reg_stall=1 for 3 cycles.
  - Response: HOLD for 4 cycles; reg_enable=0 for 3 cycles, then 1 for 1 cycle; req_ready=0 throughout; load_count=1.
- Reset mid-operation:
  - Stimulus: reset=0 asserted during a stalled HOLD.
  - Response: next cycle state=IDLE, reg_enable never pulses, counters=0, rr_ptr restarts at requester 0.
- Pipeline mode (STYLE_ARB_PIPELINE_EN):
  - Stimulus: req_valid=4'b0011 continuous, flags 1.
  - Response: after the first grant, reg_enable=1 on every cycle; grants alternate 0,1,0,1; load_count=N after N+1 cycles.

Source files
------------

// File: rtl/style_load_arbiter_if.sv
// Requester and style-register signals of the style load arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface style_load_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 59
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_primitive;
    logic [NUM_REQ-1:0]        req_valid_disp;
    logic                      reg_stall;
    logic [DATA_W-1:0]         reg_d;
    logic                      reg_enable;

    modport master (
        input  req_valid, req_data, req_primitive, req_valid_disp, reg_stall,
        output req_ready, reg_d, reg_enable
    );

    modport slave (
        output req_valid, req_data, req_primitive, req_valid_disp, reg_stall,
        input  req_ready, reg_d, reg_enable
    );
endinterface

// File: rtl/style_load_arbiter.sv
// Round-robin arbiter that sequences computed-style values into the style register.
// Define STYLE_ARB_PIPELINE_EN to re-arbitrate on the HOLD exit cycle for back-to-back loads.
module style_load_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 59,
    parameter int CNT_W   = 32,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    style_load_arbiter_if.master   bus,
    output logic [ID_W-1:0]        grant_id,
    output logic                   busy,
    output logic [CNT_W-1:0]       load_count,
    output logic [CNT_W-1:0]       drop_count
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]        state;
    logic [ID_W-1:0]   rr_ptr;
    logic [DATA_W-1:0] held_data;
    logic              held_primitive;
    logic              held_valid_disp;

    logic              held_ok;
    logic              hold_exit;
    logic              arb_open;
    logic              found;
    logic              handshake;
    logic [ID_W-1:0]   winner;
    logic [ID_W:0]     scan_sum;
    logic [ID_W-1:0]   scan_idx;
    logic [DATA_W-1:0] sel_data;
    logic              sel_primitive;
    logic              sel_valid_disp;

    assign held_ok   = held_primitive & held_valid_disp;
    // A drop leaves HOLD immediately; a real load leaves only once the register accepts it.
    assign hold_exit = (state == ST_HOLD) & (~held_ok | ~bus.reg_stall);

`ifdef STYLE_ARB_PIPELINE_EN
    assign arb_open  = (state == ST_IDLE) | hold_exit;
`else
    assign arb_open  = (state == ST_IDLE);
`endif

    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[ID_W-1:0];
            if (!found && bus.req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    always_comb begin
        sel_data       = '0;
        sel_primitive  = 1'b0;
        sel_valid_disp = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_data       = bus.req_data[i*DATA_W +: DATA_W];
                sel_primitive  = bus.req_primitive[i];
                sel_valid_disp = bus.req_valid_disp[i];
            end
        end
    end

    assign handshake = reset & arb_open & found;

    always_comb begin
        bus.req_ready = '0;
        if (handshake) begin
            bus.req_ready[winner] = 1'b1;
        end
    end

    assign bus.reg_d      = held_data;
    assign bus.reg_enable = reset & (state == ST_HOLD) & held_ok & ~bus.reg_stall;
    assign busy           = (state == ST_HOLD);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= ST_IDLE;
            rr_ptr          <= ID_W'(NUM_REQ - 1);
            held_data       <= '0;
            held_primitive  <= 1'b0;
            held_valid_disp <= 1'b0;
            grant_id        <= '0;
            load_count      <= '0;
            drop_count      <= '0;
        end else begin
            if (state == ST_HOLD) begin
                if (!held_ok) begin
                    if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
                end else if (!bus.reg_stall) begin
                    if (load_count != '1) load_count <= load_count + CNT_W'(1);
                end
            end
            if (handshake) begin
                state           <= ST_HOLD;
                held_data       <= sel_data;
                held_primitive  <= sel_primitive;
                held_valid_disp <= sel_valid_disp;
                grant_id        <= winner;
                rr_ptr          <= winner;
            end else if (hold_exit) begin
                state           <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_style_load_arbiter.sv
// Self-checking bench for style_load_arbiter: directed scenarios followed by a randomized run
// compared every cycle against a behavioural model of the grant/hold/load rules.
module tb_style_load_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 59;
    localparam int CNT_W   = 32;
    localparam int ID_W    = 2;
`ifdef STYLE_ARB_PIPELINE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    style_load_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    logic [ID_W-1:0]  grant_id;
    logic             busy;
    logic [CNT_W-1:0] load_count;
    logic [CNT_W-1:0] drop_count;

    style_load_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .grant_id   (grant_id),
        .busy       (busy),
        .load_count (load_count),
        .drop_count (drop_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: whether a value is held, what it is, who was last served, and the tallies.
    bit                m_busy;
    int                m_ptr;
    logic [DATA_W-1:0] m_data;
    bit                m_prim;
    bit                m_vd;
    int                m_gid;
    longint            m_load;
    longint            m_drop;

    logic [NUM_REQ-1:0] obs_ready;
    logic               obs_en;
    logic               obs_busy;
    logic [DATA_W-1:0]  obs_d;
    logic [ID_W-1:0]    obs_gid;
    logic [CNT_W-1:0]   obs_load;
    logic [CNT_W-1:0]   obs_drop;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic [NUM_REQ-1:0] prim,
                                 input logic [NUM_REQ-1:0] vd, input logic stall);
        bus.req_valid      = valid;
        bus.req_primitive  = prim;
        bus.req_valid_disp = vd;
        bus.reg_stall      = stall;
    endtask

    task automatic setData(input int idx, input logic [DATA_W-1:0] value);
        bus.req_data[idx*DATA_W +: DATA_W] = value;
    endtask

    task automatic modelReset();
        m_busy = 1'b0;
        m_ptr  = NUM_REQ - 1;
        m_data = '0;
        m_prim = 1'b0;
        m_vd   = 1'b0;
        m_gid  = 0;
        m_load = 0;
        m_drop = 0;
    endtask

    function automatic int modelWinner();
        bit ok;
        bit leaving;
        bit arb_ok;
        int idx;
        ok      = m_prim && m_vd;
        leaving = m_busy && (!ok || !bus.reg_stall);
        arb_ok  = !m_busy || (PIPE && leaving);
        if (!arb_ok) return -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (m_ptr + k) % NUM_REQ;
            if (bus.req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int onehotIndex(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v == (NUM_REQ'(1) << i)) return i;
        end
        return -1;
    endfunction

    // Checks the cycle's outputs against the model, then advances the model across the edge.
    task automatic stepCycle();
        int                 w;
        logic [NUM_REQ-1:0] exp_ready;
        bit                 exp_en;
        bit                 leaving;
        @(negedge clock);
        w = modelWinner();
        exp_ready = '0;
        if (reset && w >= 0) exp_ready[w] = 1'b1;
        exp_en = reset && m_busy && m_prim && m_vd && !bus.reg_stall;
        obs_ready = bus.req_ready;
        obs_en    = bus.reg_enable;
        obs_d     = bus.reg_d;
        obs_busy  = busy;
        obs_gid   = grant_id;
        obs_load  = load_count;
        obs_drop  = drop_count;
        checkOutput("req_ready",  obs_ready, exp_ready);
        checkOutput("reg_enable", obs_en,    exp_en);
        checkOutput("reg_d",      obs_d,     m_data);
        checkOutput("busy",       obs_busy,  m_busy);
        checkOutput("grant_id",   obs_gid,   m_gid);
        checkOutput("load_count", obs_load,  m_load);
        checkOutput("drop_count", obs_drop,  m_drop);
        if (!reset) begin
            modelReset();
        end else begin
            leaving = m_busy && (!(m_prim && m_vd) || !bus.reg_stall);
            if (m_busy && !(m_prim && m_vd)) begin
                if (m_drop < CNT_MAX) m_drop++;
            end else if (m_busy && !bus.reg_stall) begin
                if (m_load < CNT_MAX) m_load++;
            end
            if (w >= 0) begin
                m_data = bus.req_data[w*DATA_W +: DATA_W];
                m_prim = bus.req_primitive[w];
                m_vd   = bus.req_valid_disp[w];
                m_ptr  = w;
                m_gid  = w;
                m_busy = 1'b1;
            end else if (leaving) begin
                m_busy = 1'b0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int grants;
        logic [63:0] rnd;

        modelReset();
        reset        = 1'b0;
        bus.req_data = '0;
        applyStimulus('0, '0, '0, 1'b0);

        // Reset, then a single load from requester 2.
        stepCycle();
        stepCycle();
        reset = 1'b1;
        setData(2, 59'h1234);
        applyStimulus(4'b0100, 4'b1111, 4'b1111, 1'b0);
        stepCycle();
        checkOutput("single_ready", obs_ready, 4'b0100);
        applyStimulus(4'b0000, 4'b1111, 4'b1111, 1'b0);
        stepCycle();
        checkOutput("single_enable", obs_en, 1'b1);
        checkOutput("single_reg_d", obs_d, 59'h1234);
        checkOutput("single_grant", obs_gid, 2);
        stepCycle();
        checkOutput("single_load", obs_load, 1);
        checkOutput("single_busy", obs_busy, 1'b0);

        // Round robin with everyone requesting, starting from a fresh reset.
        reset = 1'b0;
        stepCycle();
        reset = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) setData(i, DATA_W'(64'h100 + i));
        applyStimulus(4'b1111, 4'b1111, 4'b1111, 1'b0);
        grants = 0;
        for (int c = 0; c < 40 && grants < 8; c++) begin
            stepCycle();
            if (obs_ready != '0) begin
                checkOutput("rr_order", onehotIndex(obs_ready), grants % NUM_REQ);
                grants++;
            end
        end
        checkOutput("rr_grant_total", grants, 8);
        applyStimulus(4'b0000, 4'b1111, 4'b1111, 1'b0);
        stepCycle();
        stepCycle();
        checkOutput("rr_load", obs_load, 8);
        checkOutput("rr_drop", obs_drop, 0);

        // Drop path: not a valid display value, completes in one cycle despite the stall.
        setData(1, 59'hABC);
        applyStimulus(4'b0010, 4'b1111, 4'b1101, 1'b1);
        stepCycle();
        checkOutput("drop_ready", obs_ready, 4'b0010);
        applyStimulus(4'b0000, 4'b1111, 4'b1101, 1'b1);
        stepCycle();
        checkOutput("drop_enable", obs_en, 1'b0);
        checkOutput("drop_hold_busy", obs_busy, 1'b1);
        stepCycle();
        checkOutput("drop_exit_busy", obs_busy, 1'b0);
        checkOutput("drop_count", obs_drop, 1);
        checkOutput("drop_load_kept", obs_load, 8);

        // Stalled load from requester 3.
        setData(3, 59'h7_0000_0000_0003);
        applyStimulus(4'b1000, 4'b1111, 4'b1111, 1'b1);
        stepCycle();
        checkOutput("stall_grant_ready", obs_ready, 4'b1000);
        applyStimulus(4'b1111, 4'b1111, 4'b1111, 1'b1);
        for (int c = 0; c < 3; c++) begin
            stepCycle();
            checkOutput("stall_enable_low", obs_en, 1'b0);
            checkOutput("stall_busy", obs_busy, 1'b1);
            checkOutput("stall_ready_low", obs_ready, 4'b0000);
        end
        applyStimulus(4'b0000, 4'b1111, 4'b1111, 1'b0);
        stepCycle();
        checkOutput("stall_enable_high", obs_en, 1'b1);
        stepCycle();
        checkOutput("stall_load", obs_load, 9);
        checkOutput("stall_exit_busy", obs_busy, 1'b0);

        // Reset arriving during a stalled HOLD.
        applyStimulus(4'b0001, 4'b1111, 4'b1111, 1'b1);
        stepCycle();
        applyStimulus(4'b0000, 4'b1111, 4'b1111, 1'b1);
        stepCycle();
        reset = 1'b0;
        stepCycle();
        checkOutput("rst_mid_enable", obs_en, 1'b0);
        reset = 1'b1;
        applyStimulus(4'b1111, 4'b1111, 4'b1111, 1'b0);
        stepCycle();
        checkOutput("rst_mid_ready", obs_ready, 4'b0001);
        checkOutput("rst_mid_busy", obs_busy, 1'b0);
        checkOutput("rst_mid_load", obs_load, 0);
        checkOutput("rst_mid_drop", obs_drop, 0);
        applyStimulus(4'b0000, 4'b1111, 4'b1111, 1'b0);
        stepCycle();
        stepCycle();

        // Randomized traffic, stalls and occasional resets against the model.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                rnd = {$urandom(), $urandom()};
                setData(i, rnd[DATA_W-1:0]);
            end
            applyStimulus(NUM_REQ'($urandom()),
                          NUM_REQ'($urandom() | $urandom()),
                          NUM_REQ'($urandom() | $urandom()),
                          ($urandom_range(0, 3) == 0));
            reset = ($urandom_range(0, 49) != 0);
            stepCycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
